// File: rtl/eq_lut_sequencer.sv
// Histogram-equalization LUT sequencer: walks the histogram, accumulates the CDF,
// handshakes each CDF value through the divider and writes the quotients to the LUT.
// Optional build macro EQ_LUT_SAT_EN: saturate quotients above 255 instead of truncating.
module eq_lut_sequencer #(
  parameter int NBINS  = 256,
  parameter int CDFMIN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_hist_rd_en,
  output logic [7:0]  o_hist_addr,
  input  logic [31:0] i_hist_data,
  output logic [31:0] o_cdf_in,
  output logic        o_div_en,
  input  logic [31:0] i_g_out,
  input  logic        i_ready_g_out,
  output logic        o_lut_we,
  output logic [7:0]  o_lut_addr,
  output logic [7:0]  o_lut_data,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ACC   = 3'd2,
    S_LOAD  = 3'd3,
    S_DIV   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0]  LAST_BIN = 8'(NBINS - 1);
  localparam logic [31:0] CDF_MIN  = 32'(CDFMIN);

  state_t      r_state;
  logic [7:0]  r_bin;
  logic [31:0] r_cdf;
  logic        r_hist_rd_en;
  logic [7:0]  r_hist_addr;
  logic [31:0] r_cdf_in;
  logic        r_div_en;
  logic        r_lut_we;
  logic [7:0]  r_lut_addr;
  logic [7:0]  r_lut_data;
  logic        r_busy;
  logic        r_done;
  logic [31:0] w_nxt;

  assign w_nxt = r_cdf + i_hist_data;

`ifdef EQ_LUT_SAT_EN
  function automatic logic [7:0] quantize(input logic [31:0] g);
    quantize = (g > 32'd255) ? 8'd255 : g[7:0];
  endfunction
`else
  function automatic logic [7:0] quantize(input logic [31:0] g);
    quantize = g[7:0];
  endfunction
  logic w_unused_g_hi;
  assign w_unused_g_hi = ^i_g_out[31:8];
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_bin        <= 8'd0;
      r_cdf        <= 32'd0;
      r_hist_rd_en <= 1'b0;
      r_hist_addr  <= 8'd0;
      r_cdf_in     <= 32'd0;
      r_div_en     <= 1'b0;
      r_lut_we     <= 1'b0;
      r_lut_addr   <= 8'd0;
      r_lut_data   <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_hist_rd_en <= 1'b0;
      r_lut_we     <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_bin        <= 8'd0;
            r_cdf        <= 32'd0;
            r_hist_addr  <= 8'd0;
            r_hist_rd_en <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: r_state <= S_ACC;
        S_ACC: begin
          r_cdf <= w_nxt;
          // Bins whose CDF is still below the divider minimum bypass division.
          if (w_nxt < CDF_MIN) begin
            r_lut_data <= 8'd0;
            r_lut_we   <= 1'b1;
            r_lut_addr <= r_bin;
            r_state    <= S_WRITE;
          end else begin
            r_cdf_in <= w_nxt;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_div_en <= 1'b1;
          r_state  <= S_DIV;
        end
        S_DIV: begin
          if (i_ready_g_out) begin
            r_lut_data <= quantize(i_g_out);
            r_div_en   <= 1'b0;
            r_lut_we   <= 1'b1;
            r_lut_addr <= r_bin;
            r_state    <= S_WRITE;
          end else begin
            r_state <= S_DIV;
          end
        end
        S_WRITE: begin
          if (r_bin == LAST_BIN) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bin        <= r_bin + 8'd1;
            r_hist_addr  <= r_bin + 8'd1;
            r_hist_rd_en <= 1'b1;
            r_state      <= S_READ;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_busy   <= 1'b0;
          r_div_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_hist_rd_en = r_hist_rd_en;
  assign o_hist_addr  = r_hist_addr;
  assign o_cdf_in     = r_cdf_in;
  assign o_div_en     = r_div_en;
  assign o_lut_we     = r_lut_we;
  assign o_lut_addr   = r_lut_addr;
  assign o_lut_data   = r_lut_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_eq_lut_sequencer.sv
// Self-checking bench for eq_lut_sequencer: histogram RAM and divider models plus
// a reference LUT computed directly from cumulative sums.
module tb_eq_lut_sequencer;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        o_hist_rd_en;
  logic [7:0]  o_hist_addr;
  logic [31:0] i_hist_data = 32'd0;
  logic [31:0] o_cdf_in;
  logic        o_div_en;
  logic [31:0] i_g_out = 32'd0;
  logic        i_ready_g_out = 1'b0;
  logic        o_lut_we;
  logic [7:0]  o_lut_addr;
  logic [7:0]  o_lut_data;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  eq_lut_sequencer #(.NBINS(256), .CDFMIN(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_hist_rd_en(o_hist_rd_en), .o_hist_addr(o_hist_addr), .i_hist_data(i_hist_data),
    .o_cdf_in(o_cdf_in), .o_div_en(o_div_en), .i_g_out(i_g_out), .i_ready_g_out(i_ready_g_out),
    .o_lut_we(o_lut_we), .o_lut_addr(o_lut_addr), .o_lut_data(o_lut_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] hist [256];
  logic [7:0]  exp_lut [256];
  logic [7:0]  lut_seen [256];
  logic [7:0]  lut_keep [256];
  int exp_div, exp_cycles;
  int lat = 1;
  bit noise = 1'b0;

  int wr_cnt = 0, wr_order_err = 0, div_cnt = 0, done_cnt = 0, busy_cycles = 0, hs_err = 0;
  int next_addr = 0, low_run = 100, dcnt = 0;
  logic        prev_div_en = 1'b0;
  logic [31:0] prev_cdf_in = 32'd0;
  logic        rd_pend = 1'b0;
  logic [7:0]  addr_pend = 8'd0;

  function automatic logic [31:0] div_q(input logic [31:0] c);
    logic [63:0] t;
    t = 64'(c) * 64'd255 / 64'd307200;
    return t[31:0];
  endfunction

  // Environment at the falling edge: observe outputs, then model RAM and divider.
  always @(negedge clk) begin
    if (i_reset) begin
      if (o_lut_we) begin
        lut_seen[o_lut_addr] = o_lut_data;
        if (o_lut_addr != 8'(next_addr)) wr_order_err++;
        next_addr++;
        wr_cnt++;
      end
      if (o_busy) busy_cycles++;
      if (o_done) done_cnt++;
      if (o_div_en && !prev_div_en) begin
        div_cnt++;
        if (low_run < 3) hs_err++;
      end
      if (o_div_en && (o_cdf_in !== prev_cdf_in)) hs_err++;
      if (!o_div_en && prev_div_en && !i_ready_g_out) hs_err++;
    end
    low_run = o_div_en ? 0 : low_run + 1;
    prev_div_en = o_div_en;
    prev_cdf_in = o_cdf_in;
    i_hist_data = rd_pend ? hist[addr_pend] : $urandom();
    rd_pend = o_hist_rd_en;
    addr_pend = o_hist_addr;
    if (o_div_en) begin
      dcnt++;
      if (dcnt == lat) begin
        i_ready_g_out = 1'b1;
        i_g_out = div_q(o_cdf_in);
      end else begin
        i_ready_g_out = 1'b0;
        i_g_out = $urandom();
      end
    end else begin
      dcnt = 0;
      i_ready_g_out = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_g_out = $urandom();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; wr_order_err = 0; div_cnt = 0; done_cnt = 0; busy_cycles = 0; hs_err = 0;
    next_addr = 0; low_run = 100;
    for (int i = 0; i < 256; i++) lut_seen[i] = 8'hxx;
  endtask

  task automatic compute_expect();
    logic [31:0] run;
    logic [63:0] g;
    run = 32'd0; exp_div = 0; exp_cycles = 0;
    for (int b = 0; b < 256; b++) begin
      run = run + hist[b];
      if (run < 32'd1) begin
        exp_lut[b] = 8'd0;
        exp_cycles += 3;
      end else begin
        g = 64'(run) * 64'd255 / 64'd307200;
`ifdef EQ_LUT_SAT_EN
        exp_lut[b] = (g > 64'd255) ? 8'd255 : g[7:0];
`else
        exp_lut[b] = g[7:0];
`endif
        exp_div++;
        exp_cycles += 4 + lat;
      end
    end
  endtask

  function automatic int lut_bad();
    int n = 0;
    for (int i = 0; i < 256; i++) if (lut_seen[i] !== exp_lut[i]) n++;
    return n;
  endfunction

  task automatic run_pass(input string name, input int extra_start);
    int cyc;
    compute_expect();
    clear_mon();
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_rise: got %0b want 1", name, o_busy); end
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 30000) begin
      i_start = (cyc == extra_start) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    i_start = 1'b0;
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL %s done_timeout: got %0b want 1", name, o_done); end
    tick();
  endtask

  task automatic fill_hist(input logic [31:0] v);
    for (int i = 0; i < 256; i++) hist[i] = v;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({o_hist_rd_en, o_hist_addr, o_cdf_in, o_div_en, o_lut_we, o_lut_addr, o_lut_data, o_busy, o_done} !== 61'd0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%0b div_en=%0b cdf_in=%0h want all 0", o_busy, o_div_en, o_cdf_in);
    end
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_single_mass();
    fill_hist(32'd0); hist[0] = 32'd307200;
    lat = $urandom_range(1, 4); noise = 1'b1;
    run_pass("single_mass", -1);
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL single_mass_lut: %0d bad entries want 0", lut_bad()); end
    n_checks++; if (lut_seen[255] !== 8'd255) begin n_fail++; $display("FAIL single_mass_lut255: got %0d want 255", lut_seen[255]); end
    n_checks++; if (wr_cnt != 256 || wr_order_err != 0) begin n_fail++; $display("FAIL single_mass_writes: got %0d (order err %0d) want 256", wr_cnt, wr_order_err); end
    n_checks++; if (div_cnt != 256) begin n_fail++; $display("FAIL single_mass_divs: got %0d want 256", div_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_mass_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_uniform();
    fill_hist(32'd1200);
    lat = $urandom_range(1, 3); noise = 1'b1;
    run_pass("uniform", -1);
    n_checks++; if (lut_seen[0] !== 8'd0) begin n_fail++; $display("FAIL uniform_lut0: got %0d want 0", lut_seen[0]); end
    n_checks++; if (lut_seen[127] !== 8'd127) begin n_fail++; $display("FAIL uniform_lut127: got %0d want 127", lut_seen[127]); end
    n_checks++; if (lut_seen[255] !== 8'd255) begin n_fail++; $display("FAIL uniform_lut255: got %0d want 255", lut_seen[255]); end
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL uniform_lut: %0d bad entries want 0", lut_bad()); end
    n_checks++; if (hs_err != 0) begin n_fail++; $display("FAIL uniform_handshake: got %0d errors want 0", hs_err); end
  endtask

  task automatic test_leading_empty();
    fill_hist(32'd0); hist[10] = 32'd307200;
    lat = 2; noise = 1'b1;
    run_pass("leading_empty", -1);
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL leading_empty_lut: %0d bad entries want 0", lut_bad()); end
    n_checks++; if (div_cnt != 246) begin n_fail++; $display("FAIL leading_empty_divs: got %0d want 246", div_cnt); end
    n_checks++; if (busy_cycles != 10 * 3 + 246 * 6) begin n_fail++; $display("FAIL leading_empty_cycles: got %0d want %0d", busy_cycles, 10 * 3 + 246 * 6); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 256; i++) hist[i] = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 2400));
    noise = 1'b1;
    lat = 1;
    run_pass("latency1", -1);
    for (int i = 0; i < 256; i++) lut_keep[i] = lut_seen[i];
    n_checks++; if (busy_cycles != exp_cycles) begin n_fail++; $display("FAIL latency1_cycles: got %0d want %0d", busy_cycles, exp_cycles); end
    lat = 40;
    run_pass("latency40", -1);
    n_checks++; if (busy_cycles != exp_cycles) begin n_fail++; $display("FAIL latency40_cycles: got %0d want %0d", busy_cycles, exp_cycles); end
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL latency40_lut: %0d bad entries want 0", lut_bad()); end
    for (int i = 0; i < 256; i++) exp_lut[i] = lut_keep[i];
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL latency_same_lut: %0d differing entries want 0", lut_bad()); end
    n_checks++; if (hs_err != 0) begin n_fail++; $display("FAIL latency_handshake: got %0d errors want 0", hs_err); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    fill_hist(32'd1200);
    lat = 40; noise = 1'b0;
    clear_mon();
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    cyc = 0;
    while (!(o_div_en === 1'b1 && o_hist_addr === 8'd5) && cyc < 5000) begin tick(); cyc++; end
    n_checks++; if (o_div_en !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_div5: got div_en=%0b want 1", o_div_en); end
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    n_checks++;
    if ({o_hist_rd_en, o_hist_addr, o_cdf_in, o_div_en, o_lut_we, o_lut_addr, o_lut_data, o_busy, o_done} !== 61'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy=%0b div_en=%0b lut_we=%0b want all 0", o_busy, o_div_en, o_lut_we);
    end
    i_reset = 1'b1;
    repeat (5) tick();
    n_checks++; if (wr_cnt != 5 || wr_order_err != 0) begin n_fail++; $display("FAIL reset_mid_writes: got %0d want 5", wr_cnt); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle: got busy=%0b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) hist[i] = 32'($urandom_range(0, 2400));
    lat = 3; noise = 1'b1;
    run_pass("busy_start", 60);
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL busy_start_lut: %0d bad entries want 0", lut_bad()); end
    n_checks++; if (wr_cnt != 256 || done_cnt != 1) begin n_fail++; $display("FAIL busy_start_counts: writes %0d done %0d want 256 1", wr_cnt, done_cnt); end
    repeat (5) tick();
    n_checks++; if (o_busy !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL busy_start_not_queued: busy %0b done %0d want 0 1", o_busy, done_cnt); end
    run_pass("back_to_back", -1);
    n_checks++; if (lut_bad() != 0 || wr_order_err != 0) begin n_fail++; $display("FAIL back_to_back_lut: %0d bad entries want 0", lut_bad()); end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
`ifdef EQ_LUT_SAT_EN
    want = 8'd255;
`else
    want = 8'd76;
`endif
    fill_hist(32'd0); hist[0] = 32'd400000;
    lat = 2; noise = 1'b1;
    run_pass("overflow", -1);
    n_checks++; if (lut_seen[0] !== want) begin n_fail++; $display("FAIL overflow_lut0: got %0d want %0d", lut_seen[0], want); end
    n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL overflow_lut: %0d bad entries want 0", lut_bad()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++)
        hist[i] = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 5000));
      if (r == 0) for (int i = 0; i < 4; i++) hist[i] = 32'd0;
      lat = $urandom_range(1, 6); noise = 1'b1;
      run_pass("random", -1);
      n_checks++; if (lut_bad() != 0) begin n_fail++; $display("FAIL random_lut: %0d bad entries want 0", lut_bad()); end
      n_checks++; if (div_cnt != exp_div || busy_cycles != exp_cycles) begin n_fail++; $display("FAIL random_timing: divs %0d cycles %0d want %0d %0d", div_cnt, busy_cycles, exp_div, exp_cycles); end
    end
  endtask

  initial begin
    fill_hist(32'd0);
    test_reset();
    test_single_mass();
    test_uniform();
    test_leading_empty();
    test_latency();
    test_reset_mid_div();
    test_back_to_back();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eq_lut_sequencer.md
# eq_lut_sequencer

Control sequencer that drives the histogram-equalization divider from its input side. It walks all histogram bins, accumulates the running CDF, presents each CDF value on the divider's `cdf_in`, and handshakes with `div_en`/`ready_g_out`. It then writes each quotient into the equalization LUT. It sits between the histogram RAM and the divider, and it owns the LUT write port.

## Interface
- `NBINS`, 256: number of histogram bins and LUT entries.
- `CDFMIN`, 1: must match the divider's CDFMIN; any CDF below it skips division.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a pass; ignored while `busy`.
- `hist_rd_en` out 1: histogram RAM read strobe.
- `hist_addr` out 8: histogram RAM address.
- `hist_data` in 32: read data, valid exactly 1 cycle after `hist_rd_en`.
- `cdf_in` out 32: running CDF to the divider.
- `div_en` out 1: divider start/hold.
- `g_out` in 32: divider quotient.
- `ready_g_out` in 1: divider done.
- `lut_we` out 1: LUT write strobe.
- `lut_addr` out 8: LUT write address.
- `lut_data` out 8: LUT write data.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of pass.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal registers: `bin` (8b) and `cdf` (32b accumulator, wraps mod 2^32).
- FSM states and transitions:
  - IDLE: on `start`, set `bin`=0 and `cdf`=0, then go to READ.
  - READ: drive `hist_rd_en`=1 and `hist_addr`=`bin`, then go to ACC.
  - ACC: compute `nxt` = `cdf` + `hist_data` and set `cdf` <= `nxt`.
    - If `nxt` < CDFMIN: `lut_data` <= 0, go to WRITE (skip path, no division).
    - Otherwise: `cdf_in` <= `nxt`, go to LOAD.
  - LOAD: one idle cycle so the divider registers its dividend from a stable `cdf_in`; then go to DIV.
  - DIV: `div_en`=1, held continuously. On the cycle `ready_g_out`=1, capture `g_out` into `lut_data`, deassert `div_en` next cycle, go to WRITE.
  - WRITE: drive `lut_we`=1 and `lut_addr`=`bin` for one cycle.
    - If `bin`=NBINS-1, go to DONE.
    - Otherwise increment `bin` and go to READ.
  - DONE: `done`=1 for one cycle, `busy`=0, go to IDLE.
- `cdf_in` is held stable from LOAD through the end of DIV. Between divisions it retains its last value.
- `div_en` is low for at least 3 cycles (WRITE, READ, ACC) between consecutive divisions, so the divider sees a clean restart.
- `ready_g_out` outside DIV is ignored.
- `start` during `busy` is ignored. It is not queued.
- Reset mid-operation: the next edge forces IDLE and clears all outputs. No `lut_we` is issued for the interrupted bin.

## Timing
- Skip-path bin: 3 cycles (READ, ACC, WRITE).
- Divide-path bin: 4 + k cycles, where k = number of DIV cycles including the one with `ready_g_out`.
- Full pass: sum over bins, plus 1 DONE cycle. `busy` rises the cycle after `start`.
- `lut_we` pulses exactly NBINS times per pass, addresses 0..NBINS-1 ascending.

## Configuration
- `EQ_LUT_SAT_EN`:
  - Defined: `lut_data` = 255 when `g_out` > 255, else `g_out[7:0]`.
  - Undefined: `lut_data` = `g_out[7:0]` (truncation).
  - The skip path writes 0 in both builds.

## Test plan
- Single mass: hist[0]=307200, others 0 -> all 256 entries = 255. 256 `lut_we` pulses, one `done`, 256 divisions.
- Uniform: every bin 1200 -> lut[0]=0, lut[127]=127, lut[255]=255.
- Leading empty bins: hist[0..9]=0, hist[10]=307200 -> lut[0..9]=0. Each of those bins takes 3 cycles with no `div_en`; lut[10..255]=255.
- Handshake latency: divider model with `ready_g_out` after 1 and after 40 cycles -> identical LUT contents. `div_en` stays high throughout DIV, and `cdf_in` is stable from LOAD through DIV.
- Reset mid-DIV at bin 5 -> next cycle all outputs 0 and no `lut_we` for bin 5. A following `start` yields a complete, correct pass; `start` pulsed while busy has no effect.
- Overflow: hist[0]=400000 -> `g_out`=332. With `EQ_LUT_SAT_EN`, lut[0]=255; without it, lut[0]=76.
